// File: rtl/alu_arbiter_pkg.sv
// Shared defaults and FSM encoding for the two-requester ALU arbiter.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 7;
  localparam int FLAGW_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant history is held by the caller.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    // On a tie the requester that did not win last time goes first.
    if (&req_valid) grant = ~last_grant;
    else            grant = req_valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external combinational ALU between two requesters,
// returning each result with its owner ID over a backpressured channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int FLAGW = FLAGW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic [FLAGW-1:0] alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_carry,
  output logic [FLAGW-1:0] resp_flags,
  output logic             busy
);

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   owner_p0;
  logic   grant;
  logic   grant_vld;
  logic   can_accept;
  logic   accept;

  rr_arb2 u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_vld)
  );

  // A slot opens when idle, or when the pending response leaves this cycle.
  always_comb begin
    can_accept = (state == IDLE) || ((state == RESP) && resp_ready);
    accept     = can_accept && grant_vld;
    req_ready  = 2'b00;
    if (accept) req_ready = grant ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_p0   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        owner_p0   <= grant;
      end
    end
  end

  // Stage p0: operands registered toward the ALU on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      alu_a      <= grant ? req1_a      : req0_a;
      alu_b      <= grant ? req1_b      : req0_b;
      alu_opcode <= grant ? req1_opcode : req0_opcode;
    end
  end

  // Stage p1: ALU result captured at the end of the EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_out   <= '0;
      resp_carry <= 1'b0;
      resp_flags <= '0;
      resp_id    <= 1'b0;
    end else if (state == EXEC) begin
      resp_out   <= alu_out;
      resp_carry <= alu_carry;
      resp_flags <= alu_flags;
      resp_id    <= owner_p0;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule
